// File: rtl/serial_addr_decoder.sv
// ---------------------------------------------------------------------------
// serial_addr_decoder
//
// Bit-serial address decoder for the shared serial bus. The granted master
// shifts its address in MSB first while A_ADD is high; the top DEV_BITS of
// the address select one of SLV_N slaves. The select is held for the whole
// transaction (while B_UTIL stays high). Slaves enabled in SPLIT_EN may
// split a transaction by raising B_SBSY; the decoder remembers them and
// offers a resume select once the slave drops B_SBSY again.
//
// Ports
//   CLK        bus clock, rising edge
//   RST        synchronous active-high reset
//   B_UTIL     bus utilised by the granted master
//   A_ADD      address phase strobe, one address bit per cycle
//   B_BUS_OUT  serial data from the granted master
//   B_SBSY     per-slave split-busy flags
//   AD_SEL     one-hot slave select
//   AD_VALID   AD_SEL is valid
//   AD_ERR     decode error (unmapped slave index or short address)
//   AD_ADDR    captured address, held while AD_VALID is high
//   SPL_SEL    one-hot select of the lowest split slave ready to resume
//   SPL_PEND   at least one split transaction is outstanding
//
// ADDR_W must be at least DEV_BITS; SLV_N is 2..16.
// ---------------------------------------------------------------------------
module serial_addr_decoder #(
    parameter int          ADDR_W   = 16,
    parameter int          SLV_N    = 4,
    parameter logic [15:0] SPLIT_EN = 16'h0008
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              B_UTIL,
    input  logic              A_ADD,
    input  logic              B_BUS_OUT,
    input  logic [SLV_N-1:0]  B_SBSY,
    output logic [SLV_N-1:0]  AD_SEL,
    output logic              AD_VALID,
    output logic              AD_ERR,
    output logic [ADDR_W-1:0] AD_ADDR,
    output logic [SLV_N-1:0]  SPL_SEL,
    output logic              SPL_PEND
);

    localparam int                DEV_BITS   = $clog2(SLV_N);
    localparam int                CNT_W      = $clog2(ADDR_W + 1);
    localparam logic [SLV_N-1:0]  SPLIT_MASK = SPLIT_EN[SLV_N-1:0];
    // One extra bit so SLV_N itself (e.g. 4 with a 2-bit index) is representable.
    localparam logic [DEV_BITS:0] SLV_LIMIT  = (DEV_BITS + 1)'(SLV_N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DECODE,
        S_SELECT,
        S_ERROR
    } state_t;

    state_t state, state_nxt;

    // Datapath
    logic [ADDR_W-1:0]   shreg;
    logic [CNT_W-1:0]    cnt;
    logic [SLV_N-1:0]    sel_q;
    logic [ADDR_W-1:0]   addr_q;

    // Split tracking and bus-ownership edge detect
    logic [SLV_N-1:0]    pend;
    logic [SLV_N-1:0]    pend_nxt;
    logic [SLV_N-1:0]    spl_sel_q;
    logic                b_util_q;

    // Strobes from the next-state logic into the datapath
    logic                addr_start;
    logic                addr_shift;
    logic                dec_hit;
    logic                resume;
    logic                split_hit;

    logic [DEV_BITS-1:0] idx;
    logic [SLV_N-1:0]    idx_onehot;
    logic                last_bit;

    // Lowest set bit of v as a one-hot vector (zero if v is zero).
    function automatic logic [SLV_N-1:0] lowest_one(input logic [SLV_N-1:0] v);
        logic [SLV_N-1:0] r;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < SLV_N; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign idx      = shreg[ADDR_W-1 -: DEV_BITS];
    // cnt counts bits already shifted in; this is the bit that completes the address.
    assign last_bit = (cnt == CNT_W'(ADDR_W - 1));

    always_comb begin
        idx_onehot = '0;
        for (int i = 0; i < SLV_N; i++) begin
            idx_onehot[i] = (idx == DEV_BITS'(i));
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt  = state;
        addr_start = 1'b0;
        addr_shift = 1'b0;
        dec_hit    = 1'b0;
        resume     = 1'b0;
        split_hit  = 1'b0;
        case (state)
            S_IDLE: begin
                // A new address phase wins over a pending split resume.
                if (A_ADD && B_UTIL) begin
                    addr_start = 1'b1;
                    state_nxt  = (ADDR_W == 1) ? S_DECODE : S_ADDR;
                end else if (B_UTIL && !b_util_q && (|spl_sel_q)) begin
                    resume    = 1'b1;
                    state_nxt = S_SELECT;
                end
            end
            S_ADDR: begin
                if (!B_UTIL) begin
                    state_nxt = S_IDLE;
                end else if (A_ADD) begin
                    addr_shift = 1'b1;
                    if (last_bit) begin
                        state_nxt = S_DECODE;
                    end
                end else begin
                    state_nxt = S_ERROR;
                end
            end
            S_DECODE: begin
                if (!B_UTIL) begin
                    state_nxt = S_IDLE;
                end else if ({1'b0, idx} < SLV_LIMIT) begin
                    dec_hit   = 1'b1;
                    state_nxt = S_SELECT;
                end else begin
                    state_nxt = S_ERROR;
                end
            end
            S_SELECT: begin
                // Busy from a slave that may not split is ignored by the mask.
                if (!B_UTIL) begin
                    state_nxt = S_IDLE;
                end else if (|(B_SBSY & sel_q & SPLIT_MASK)) begin
                    split_hit = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_ERROR: begin
                if (!B_UTIL) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        AD_SEL   = '0;
        AD_VALID = 1'b0;
        AD_ERR   = 1'b0;
        AD_ADDR  = '0;
        case (state)
            S_SELECT: begin
                AD_SEL   = sel_q;
                AD_VALID = 1'b1;
                AD_ADDR  = addr_q;
            end
            S_ERROR:  AD_ERR = 1'b1;
            default:  ;
        endcase
    end

    assign SPL_SEL  = spl_sel_q;
    assign SPL_PEND = |pend;

    always_comb begin
        pend_nxt = pend;
        if (resume) begin
            pend_nxt = pend & ~spl_sel_q;
        end
        if (split_hit) begin
            pend_nxt = pend | sel_q;
        end
    end

    // ---------------- split tracking (control, reset) ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend      <= '0;
            spl_sel_q <= '0;
            b_util_q  <= 1'b0;
        end else begin
            pend      <= pend_nxt;
            // Built from pend_nxt so a bit cleared by a resume never re-offers itself.
            spl_sel_q <= lowest_one(pend_nxt & ~B_SBSY);
            b_util_q  <= B_UTIL;
        end
    end

    // ---------------- address datapath (no reset, outputs gated by state) ----------------
    always_ff @(posedge CLK) begin
        if (addr_start) begin
            shreg <= ADDR_W'({shreg, B_BUS_OUT});
            cnt   <= CNT_W'(1);
        end else if (addr_shift) begin
            shreg <= ADDR_W'({shreg, B_BUS_OUT});
            cnt   <= cnt + CNT_W'(1);
        end
        if (dec_hit) begin
            sel_q  <= idx_onehot;
            addr_q <= shreg;
        end else if (resume) begin
            // The resumed transaction has no freshly captured address.
            sel_q  <= spl_sel_q;
            addr_q <= '0;
        end
    end

endmodule

// File: tb/tb_serial_addr_decoder.sv
// ---------------------------------------------------------------------------
// tb_serial_addr_decoder
//
// Two decoders share one stimulus: the default 4-slave build (slave 3 may
// split) and a 3-slave build whose index 3 is unmapped. A transaction-level
// reference model of the 4-slave build tracks collected address bits,
// current owner, error flag and pending splits, and is compared with the
// DUT on every falling edge. Directed sequences and an address table cover
// the named corner cases; a randomized session loop follows.
// ---------------------------------------------------------------------------
module tb_serial_addr_decoder;

    localparam int ADDR_W = 16;
    localparam bit [3:0] MDL_SPLIT = 4'b1000;

    logic        CLK       = 1'b0;
    logic        RST       = 1'b1;
    logic        B_UTIL    = 1'b0;
    logic        A_ADD     = 1'b0;
    logic        B_BUS_OUT = 1'b0;
    logic [3:0]  B_SBSY    = 4'b0000;

    logic [3:0]  ad_sel4, spl_sel4;
    logic        ad_valid4, ad_err4, spl_pend4;
    logic [15:0] ad_addr4;

    logic [2:0]  ad_sel3, spl_sel3;
    logic        ad_valid3, ad_err3, spl_pend3;
    logic [15:0] ad_addr3;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 CLK = ~CLK;

    serial_addr_decoder #(.ADDR_W(16), .SLV_N(4), .SPLIT_EN(16'h0008)) dut4 (
        .CLK(CLK), .RST(RST), .B_UTIL(B_UTIL), .A_ADD(A_ADD), .B_BUS_OUT(B_BUS_OUT),
        .B_SBSY(B_SBSY), .AD_SEL(ad_sel4), .AD_VALID(ad_valid4), .AD_ERR(ad_err4),
        .AD_ADDR(ad_addr4), .SPL_SEL(spl_sel4), .SPL_PEND(spl_pend4)
    );

    serial_addr_decoder #(.ADDR_W(16), .SLV_N(3), .SPLIT_EN(16'h0008)) dut3 (
        .CLK(CLK), .RST(RST), .B_UTIL(B_UTIL), .A_ADD(A_ADD), .B_BUS_OUT(B_BUS_OUT),
        .B_SBSY(B_SBSY[2:0]), .AD_SEL(ad_sel3), .AD_VALID(ad_valid3), .AD_ERR(ad_err3),
        .AD_ADDR(ad_addr3), .SPL_SEL(spl_sel3), .SPL_PEND(spl_pend3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance past the next rising edge; outputs are settled afterwards.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_bits(input logic [15:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            A_ADD = 1'b1;
            if (i < 16) B_BUS_OUT = a[15-i];
            else        B_BUS_OUT = 1'($urandom);
            step();
        end
        A_ADD     = 1'b0;
        B_BUS_OUT = 1'b0;
    endtask

    task automatic rand_sbsy();
        if ($urandom_range(0, 3) == 0) B_SBSY = 4'($urandom);
    endtask

    // ---------------- reference model (4 slaves, slave 3 may split) ----------------
    logic        m_bits[$];
    bit          m_collect   = 1'b0;
    bit          m_decode    = 1'b0;
    bit          m_err       = 1'b0;
    bit          m_prev_util = 1'b0;
    int          m_owner     = -1;
    bit   [3:0]  m_pend      = 4'b0;
    bit   [3:0]  m_splsel    = 4'b0;
    logic [15:0] m_addr      = 16'h0;

    task automatic model_step();
        bit          util, aadd, din;
        bit   [3:0]  sbsy;
        logic [15:0] a;
        int          idx;
        util = B_UTIL;
        aadd = A_ADD;
        din  = B_BUS_OUT;
        sbsy = B_SBSY;
        if (RST) begin
            m_bits.delete();
            m_collect   = 1'b0;
            m_decode    = 1'b0;
            m_err       = 1'b0;
            m_owner     = -1;
            m_pend      = 4'b0;
            m_splsel    = 4'b0;
            m_prev_util = 1'b0;
            m_addr      = 16'h0;
            return;
        end
        if (!m_collect && !m_decode && m_owner < 0 && !m_err) begin
            if (aadd && util) begin
                m_bits.delete();
                m_bits.push_back(din);
                m_collect = 1'b1;
            end else if (util && !m_prev_util && m_splsel != 0) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (m_splsel[i]) idx = i;
                m_owner      = idx;
                m_pend[idx]  = 1'b0;
                m_addr       = 16'h0;
            end
        end else if (m_collect) begin
            if (!util) begin
                m_collect = 1'b0;
            end else if (aadd) begin
                m_bits.push_back(din);
                if (m_bits.size() == ADDR_W) begin
                    m_collect = 1'b0;
                    m_decode  = 1'b1;
                end
            end else begin
                m_collect = 1'b0;
                m_err     = 1'b1;
            end
        end else if (m_decode) begin
            m_decode = 1'b0;
            if (util) begin
                a = 16'h0;
                foreach (m_bits[i]) a = {a[14:0], m_bits[i]};
                idx = int'(a / 16'h4000);
                if (idx < 4) begin
                    m_owner = idx;
                    m_addr  = a;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (m_owner >= 0) begin
            if (!util) begin
                m_owner = -1;
            end else if (sbsy[m_owner] && MDL_SPLIT[m_owner]) begin
                m_pend[m_owner] = 1'b1;
                m_owner         = -1;
            end
        end else if (!util) begin
            m_err = 1'b0;
        end
        m_splsel = 4'b0;
        for (int i = 0; i < 4; i++) begin
            if (m_pend[i] && !sbsy[i] && m_splsel == 0) m_splsel[i] = 1'b1;
        end
        m_prev_util = util;
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            model_step();
        end
    end

    initial begin
        logic [3:0] esel;
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                esel = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
                chk("mdl_sel",      32'(ad_sel4),   32'(esel));
                chk("mdl_valid",    32'(ad_valid4), 32'(m_owner >= 0));
                chk("mdl_err",      32'(ad_err4),   32'(m_err));
                chk("mdl_addr",     32'(ad_addr4),  (m_owner >= 0) ? 32'(m_addr) : 32'h0);
                chk("mdl_spl_sel",  32'(spl_sel4),  32'(m_splsel));
                chk("mdl_spl_pend", 32'(spl_pend4), 32'(m_pend != 0));
            end
        end
    end

    // ---------------- directed and randomized stimulus ----------------
    typedef struct {
        logic [15:0] addr;
        logic [3:0]  sel4;
        logic [2:0]  sel3;
        logic        err3;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          kind;
        int          nb;
        logic [15:0] ra;

        vecs[0] = '{16'hB3C5, 4'b0100, 3'b100, 1'b0};
        vecs[1] = '{16'hC000, 4'b1000, 3'b000, 1'b1};
        vecs[2] = '{16'h4000, 4'b0010, 3'b010, 1'b0};
        vecs[3] = '{16'h0000, 4'b0001, 3'b001, 1'b0};
        vecs[4] = '{16'hFFFF, 4'b1000, 3'b000, 1'b1};
        vecs[5] = '{16'h8001, 4'b0100, 3'b100, 1'b0};
        vecs[6] = '{16'h7FFF, 4'b0010, 3'b010, 1'b0};

        RST = 1'b1;
        repeat (3) step();
        RST = 1'b0;
        chk_en = 1'b1;

        // Reset state of both builds
        chk("rst_sel4",   32'(ad_sel4),   0);
        chk("rst_valid4", 32'(ad_valid4), 0);
        chk("rst_err4",   32'(ad_err4),   0);
        chk("rst_addr4",  32'(ad_addr4),  0);
        chk("rst_spl4",   32'(spl_sel4),  0);
        chk("rst_pend4",  32'(spl_pend4), 0);
        chk("rst_sel3",   32'(ad_sel3),   0);
        chk("rst_err3",   32'(ad_err3),   0);
        chk("rst_pend3",  32'(spl_pend3), 0);

        // B3C5: exact latency, hold, clear on B_UTIL drop
        B_UTIL = 1'b1;
        step();
        send_bits(16'hB3C5, 16);
        chk("b3c5_decode_gap", 32'(ad_valid4), 0);
        step();
        chk("b3c5_sel",   32'(ad_sel4),   32'h4);
        chk("b3c5_valid", 32'(ad_valid4), 1);
        chk("b3c5_addr",  32'(ad_addr4),  32'hB3C5);
        step();
        step();
        chk("b3c5_hold", 32'(ad_sel4), 32'h4);
        B_UTIL = 1'b0;
        step();
        chk("b3c5_clr_sel",   32'(ad_sel4),   0);
        chk("b3c5_clr_valid", 32'(ad_valid4), 0);
        chk("b3c5_clr_addr",  32'(ad_addr4),  0);
        step();

        // Address table through both builds
        for (int v = 0; v < 7; v++) begin
            B_UTIL = 1'b1;
            step();
            send_bits(vecs[v].addr, 16);
            step();
            chk($sformatf("tbl%0d_sel4", v), 32'(ad_sel4), 32'(vecs[v].sel4));
            chk($sformatf("tbl%0d_sel3", v), 32'(ad_sel3), 32'(vecs[v].sel3));
            chk($sformatf("tbl%0d_err3", v), 32'(ad_err3), 32'(vecs[v].err3));
            step();
            chk($sformatf("tbl%0d_hold_err3", v), 32'(ad_err3), 32'(vecs[v].err3));
            chk($sformatf("tbl%0d_hold_sel3", v), 32'(ad_sel3), 32'(vecs[v].sel3));
            B_UTIL = 1'b0;
            step();
            chk($sformatf("tbl%0d_clr_sel4", v), 32'(ad_sel4), 0);
            chk($sformatf("tbl%0d_clr_err3", v), 32'(ad_err3), 0);
            step();
        end

        // Short address: A_ADD drops after 9 bits
        B_UTIL = 1'b1;
        step();
        send_bits(16'hFFFF, 9);
        step();
        chk("short_err",   32'(ad_err4),   1);
        chk("short_valid", 32'(ad_valid4), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("short_hold_err",   32'(ad_err4),   1);
            chk("short_hold_valid", 32'(ad_valid4), 0);
        end
        B_UTIL = 1'b0;
        step();
        chk("short_clr_err", 32'(ad_err4), 0);
        step();

        // Split on slave 3 and resume
        B_UTIL = 1'b1;
        step();
        send_bits(16'hC000, 16);
        step();
        chk("split_sel", 32'(ad_sel4), 32'h8);
        B_SBSY = 4'b1000;
        step();
        chk("split_sel_clr", 32'(ad_sel4),   0);
        chk("split_pend",    32'(spl_pend4), 1);
        chk("split_spl_busy", 32'(spl_sel4), 0);
        B_SBSY = 4'b0000;
        step();
        chk("split_spl_ready", 32'(spl_sel4), 32'h8);
        B_UTIL = 1'b0;
        step();
        chk("split_no_resume_low", 32'(ad_sel4), 0);
        B_UTIL = 1'b1;
        step();
        chk("resume_sel",      32'(ad_sel4),   32'h8);
        chk("resume_valid",    32'(ad_valid4), 1);
        chk("resume_pend",     32'(spl_pend4), 0);
        chk("resume_spl_sel",  32'(spl_sel4),  0);
        B_UTIL = 1'b0;
        step();

        // Busy from a non-splitting slave is ignored
        B_UTIL = 1'b1;
        step();
        send_bits(16'h4000, 16);
        step();
        chk("nosplit_sel", 32'(ad_sel4), 32'h2);
        B_SBSY = 4'b0010;
        step();
        step();
        chk("nosplit_hold_sel", 32'(ad_sel4),   32'h2);
        chk("nosplit_valid",    32'(ad_valid4), 1);
        chk("nosplit_pend",     32'(spl_pend4), 0);
        B_SBSY = 4'b0000;
        B_UTIL = 1'b0;
        step();

        // Reset in the middle of an address phase, then a fresh address
        B_UTIL = 1'b1;
        step();
        send_bits(16'hFFFF, 7);
        RST = 1'b1;
        step();
        chk("midrst_sel",   32'(ad_sel4),   0);
        chk("midrst_valid", 32'(ad_valid4), 0);
        chk("midrst_err",   32'(ad_err4),   0);
        chk("midrst_pend",  32'(spl_pend4), 0);
        RST = 1'b0;
        send_bits(16'h4000, 16);
        step();
        chk("midrst_fresh_sel", 32'(ad_sel4), 32'h2);
        B_UTIL = 1'b0;
        step();

        // Randomized sessions checked by the reference model
        for (int s = 0; s < 90; s++) begin
            kind = $urandom_range(0, 9);
            ra   = 16'($urandom);
            B_UTIL = 1'b1;
            step();
            if (kind == 0) begin
                repeat ($urandom_range(1, 4)) begin
                    rand_sbsy();
                    step();
                end
            end else begin
                if (kind == 1)      nb = $urandom_range(1, 15);
                else if (kind == 2) nb = $urandom_range(17, 20);
                else                nb = 16;
                send_bits(ra, nb);
                repeat ($urandom_range(1, 6)) begin
                    rand_sbsy();
                    step();
                end
            end
            B_UTIL = 1'b0;
            A_ADD  = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                rand_sbsy();
                step();
            end
        end

        @(negedge CLK);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
